// File: rtl/matmul_drv.sv
// Command-stream initiator for the byte-stream matrix-vector multiply engine.
// Optional cycle counter enabled by defining MATMUL_DRV_CYCLES_EN.
module matmul_drv #(
    parameter int MAX_DIM = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic [7:0]               vdim,
    input  logic [7:0]               hdim,
    input  logic                     vec_we,
    input  logic [$clog2(MAX_DIM)-1:0]   vec_addr,
    input  logic [7:0]               vec_wdata,
    input  logic                     mat_we,
    input  logic [2*$clog2(MAX_DIM)-1:0] mat_addr,
    input  logic [7:0]               mat_wdata,
    output logic [7:0]               tx_data,
    output logic                     tx_valid,
    input  logic                     tx_ready,
    input  logic [31:0]              rx_data,
    input  logic                     rx_valid,
    output logic                     rx_ready,
    input  logic [$clog2(MAX_DIM)-1:0]   res_raddr,
    output logic [31:0]              res_rdata,
    output logic                     busy,
    output logic                     done,
    output logic                     err,
    output logic [31:0]              cycles
);

    localparam int AW = $clog2(MAX_DIM);
    localparam logic [7:0]    MAX_D  = 8'(MAX_DIM);
    localparam logic [AW-1:0] ZERO_A = '0;

    typedef enum logic [2:0] {IDLE, HDR_V, HDR_H, VEC, MAT, WAIT_RES, DONE} state_t;

    state_t      state, state_nx;
    logic [7:0]  vec_mem [MAX_DIM];
    logic [7:0]  mat_mem [MAX_DIM*MAX_DIM];
    logic [31:0] res_mem [MAX_DIM];
    logic [7:0]  vdim_q, hdim_q, row, col;
    logic [7:0]  col_inc, row_inc;
    logic [7:0]  tx_data_nx;
    logic        tx_valid_nx;
    logic        accept, dim_bad, xfer, cap, last_col, last_row;

    assign accept   = (state == IDLE) && start;
    assign dim_bad  = (vdim == 8'd0) || (hdim == 8'd0) || (vdim > MAX_D) || (hdim > MAX_D);
    assign xfer     = tx_valid && tx_ready;
    assign cap      = (state == WAIT_RES) && rx_valid && rx_ready;
    assign col_inc  = col + 8'd1;
    assign row_inc  = row + 8'd1;
    assign last_col = (col == hdim_q - 8'd1);
    assign last_row = (row == vdim_q - 8'd1);

    // NOTE: buffers are plain storage with no reset, so contents survive rst as intended.
    always_ff @(posedge clk) begin
        if (vec_we && !busy) vec_mem[vec_addr] <= vec_wdata;
        if (mat_we && !busy) mat_mem[mat_addr] <= mat_wdata;
        if (cap)             res_mem[row[AW-1:0]] <= rx_data;
    end

    // NOTE: every sequential assignment is non-blocking so all registers update from pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            tx_valid  <= 1'b0;
            tx_data   <= 8'd0;
            busy      <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
            row       <= 8'd0;
            col       <= 8'd0;
            vdim_q    <= 8'd0;
            hdim_q    <= 8'd0;
            res_rdata <= 32'd0;
        end else begin
            state     <= state_nx;
            tx_valid  <= tx_valid_nx;
            tx_data   <= tx_data_nx;
            done      <= (state == DONE);
            res_rdata <= res_mem[res_raddr];
            if (accept) begin
                vdim_q <= vdim;
                hdim_q <= hdim;
                err    <= dim_bad;
                busy   <= 1'b1;
                row    <= 8'd0;
                col    <= 8'd0;
            end else if (state == DONE) begin
                busy <= 1'b0;
            end
            if ((state == VEC || state == MAT) && xfer)
                col <= last_col ? 8'd0 : col_inc;
            if (cap)
                row <= row_inc;
        end
    end

    always_comb begin
        // NOTE: default first so no path leaves state_nx unassigned (no latch).
        state_nx = state;
        case (state)
            IDLE:     if (start) state_nx = dim_bad ? DONE : HDR_V;
            HDR_V:    if (xfer) state_nx = HDR_H;
            HDR_H:    if (xfer) state_nx = VEC;
            VEC:      if (xfer && last_col) state_nx = MAT;
            MAT:      if (xfer && last_col) state_nx = WAIT_RES;
            WAIT_RES: if (cap) state_nx = last_row ? DONE : MAT;
            DONE:     state_nx = IDLE;
            default:  state_nx = IDLE;
        endcase
    end

    // Next byte is prefetched on each transfer so the registered stream has no bubbles.
    always_comb begin
        tx_valid_nx = tx_valid;
        tx_data_nx  = tx_data;
        rx_ready    = (state == MAT) || (state == WAIT_RES);
        case (state)
            IDLE: begin
                if (start && !dim_bad) begin
                    tx_valid_nx = 1'b1;
                    tx_data_nx  = vdim;
                end
            end
            HDR_V: if (xfer) tx_data_nx = hdim_q;
            HDR_H: if (xfer) tx_data_nx = vec_mem[ZERO_A];
            VEC: begin
                if (xfer)
                    tx_data_nx = last_col ? mat_mem[{ZERO_A, ZERO_A}] : vec_mem[col_inc[AW-1:0]];
            end
            MAT: begin
                if (xfer) begin
                    if (last_col) tx_valid_nx = 1'b0;
                    else          tx_data_nx  = mat_mem[{row[AW-1:0], col_inc[AW-1:0]}];
                end
            end
            WAIT_RES: begin
                if (cap && !last_row) begin
                    tx_valid_nx = 1'b1;
                    tx_data_nx  = mat_mem[{row_inc[AW-1:0], ZERO_A}];
                end
            end
            default: ;
        endcase
    end

`ifdef MATMUL_DRV_CYCLES_EN
    logic [31:0] cyc_q;
    // The accepting edge is the first counted edge; counting stops once back in IDLE.
    always_ff @(posedge clk) begin
        if (rst)                cyc_q <= 32'd0;
        else if (accept)        cyc_q <= 32'd1;
        else if (state != IDLE) cyc_q <= cyc_q + 32'd1;
    end
    assign cycles = cyc_q;
`else
    assign cycles = 32'd0;
`endif

endmodule
